// File: rtl/cpu_bus_initiator_if.sv
// Request port and 65C816-style external bus, bundled for the initiator.
// Combinational bundle only; timing and backpressure belong to the initiator.
// The master side drives the bus and accepts requests. The slave side is the requester/responder.
interface cpu_bus_initiator_if;
    logic        req;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        req_we;
    logic [7:0]  req_wdata;
    logic        req_vp;
    logic        done;
    logic [7:0]  rdata;
    logic        phi2;
    logic [15:0] ab;
    logic [7:0]  db_out;
    logic        db_oe;
    logic [7:0]  db_in;
    logic        rwb;
    logic        vda;
    logic        vpa;
    logic        rdy;

    modport master (
        input  req, req_addr, req_we, req_wdata, req_vp, db_in, rdy,
        output req_ready, done, rdata, phi2, ab, db_out, db_oe, rwb, vda, vpa
    );

    modport slave (
        output req, req_addr, req_we, req_wdata, req_vp, db_in, rdy,
        input  req_ready, done, rdata, phi2, ab, db_out, db_oe, rwb, vda, vpa
    );
endinterface

// File: rtl/cpu_bus_initiator.sv
// Bus initiator: generates phi2 and runs one 65C816-style bus cycle per request.
// Latency: starts at the next phi2 falling edge; done follows 2*PHI_DIV clk later, plus that again per rdy-low stretch.
// Backpressure: one-entry pending slot, req_ready low while it is occupied; rdy low repeats the bus cycle.
module cpu_bus_initiator #(
    parameter int PHI_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_bus_initiator_if.master  bus
);
    localparam int CW = (PHI_DIV > 1) ? $clog2(PHI_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PHI_DIV - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        phi2_q, phi2_d;

    logic        pending_q, pending_d;
    logic [23:0] pend_addr_q, pend_addr_d;
    logic        pend_we_q, pend_we_d;
    logic [7:0]  pend_wdata_q, pend_wdata_d;
    logic        pend_vp_q, pend_vp_d;

    logic [7:0]  cur_bank_q, cur_bank_d;
    logic        cur_we_q, cur_we_d;
    logic [7:0]  cur_wdata_q, cur_wdata_d;

    logic [15:0] ab_q, ab_d;
    logic [7:0]  db_out_q, db_out_d;
    logic        db_oe_q, db_oe_d;
    logic        rwb_q, rwb_d;
    logic        vda_q, vda_d;
    logic        vpa_q, vpa_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        cnt_last;
    logic        rise;
    logic        boundary;

    always_comb begin
        cnt_last = (cnt_q == CNT_LAST);
        rise     = cnt_last && !phi2_q;
        boundary = cnt_last && phi2_q;

        state_d      = state_q;
        cnt_d        = cnt_last ? '0 : cnt_q + CW'(1);
        phi2_d       = cnt_last ? ~phi2_q : phi2_q;
        pending_d    = pending_q;
        pend_addr_d  = pend_addr_q;
        pend_we_d    = pend_we_q;
        pend_wdata_d = pend_wdata_q;
        pend_vp_d    = pend_vp_q;
        cur_bank_d   = cur_bank_q;
        cur_we_d     = cur_we_q;
        cur_wdata_d  = cur_wdata_q;
        ab_d         = ab_q;
        db_out_d     = db_out_q;
        db_oe_d      = db_oe_q;
        rwb_d        = rwb_q;
        vda_d        = vda_q;
        vpa_d        = vpa_q;
        done_d       = 1'b0;
        rdata_d      = rdata_q;

        // A slot filled on a boundary edge is only seen at the following boundary.
        if (bus.req && !pending_q) begin
            pending_d    = 1'b1;
            pend_addr_d  = bus.req_addr;
            pend_we_d    = bus.req_we;
            pend_wdata_d = bus.req_wdata;
            pend_vp_d    = bus.req_vp;
        end

        if (boundary) begin
            if (state_q == ST_ACTIVE && bus.rdy) begin
                done_d = 1'b1;
                if (!cur_we_q) begin
                    rdata_d = bus.db_in;
                end
            end

            if (state_q == ST_ACTIVE && !bus.rdy) begin
                // Stretched cycle: address/control stay put, bank goes back on the bus.
                db_oe_d  = 1'b1;
                db_out_d = cur_bank_q;
            end else if (pending_q) begin
                state_d     = ST_ACTIVE;
                pending_d   = 1'b0;
                cur_bank_d  = pend_addr_q[23:16];
                cur_we_d    = pend_we_q;
                cur_wdata_d = pend_wdata_q;
                ab_d        = pend_addr_q[15:0];
                rwb_d       = ~pend_we_q;
                vda_d       = 1'b1;
                vpa_d       = pend_vp_q;
                db_oe_d     = 1'b1;
                db_out_d    = pend_addr_q[23:16];
            end else begin
                state_d = ST_IDLE;
                vda_d   = 1'b0;
                vpa_d   = 1'b0;
                rwb_d   = 1'b1;
                db_oe_d = 1'b0;
            end
        end else if (rise && state_q == ST_ACTIVE) begin
            db_oe_d = cur_we_q;
            if (cur_we_q) begin
                db_out_d = cur_wdata_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            phi2_q       <= 1'b0;
            pending_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_we_q    <= 1'b0;
            pend_wdata_q <= '0;
            pend_vp_q    <= 1'b0;
            cur_bank_q   <= '0;
            cur_we_q     <= 1'b0;
            cur_wdata_q  <= '0;
            ab_q         <= '0;
            db_out_q     <= '0;
            db_oe_q      <= 1'b0;
            rwb_q        <= 1'b1;
            vda_q        <= 1'b0;
            vpa_q        <= 1'b0;
            done_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phi2_q       <= phi2_d;
            pending_q    <= pending_d;
            pend_addr_q  <= pend_addr_d;
            pend_we_q    <= pend_we_d;
            pend_wdata_q <= pend_wdata_d;
            pend_vp_q    <= pend_vp_d;
            cur_bank_q   <= cur_bank_d;
            cur_we_q     <= cur_we_d;
            cur_wdata_q  <= cur_wdata_d;
            ab_q         <= ab_d;
            db_out_q     <= db_out_d;
            db_oe_q      <= db_oe_d;
            rwb_q        <= rwb_d;
            vda_q        <= vda_d;
            vpa_q        <= vpa_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.req_ready = ~pending_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.phi2      = phi2_q;
    assign bus.ab        = ab_q;
    assign bus.db_out    = db_out_q;
    assign bus.db_oe     = db_oe_q;
    assign bus.rwb       = rwb_q;
    assign bus.vda       = vda_q;
    assign bus.vpa       = vpa_q;
endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Directed bench for cpu_bus_initiator: scoreboard of expected rdata per done pulse plus bus-level checks.
module tb_cpu_bus_initiator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       ovr = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] din1 = 8'h42;
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    cpu_bus_initiator_if bus0();
    cpu_bus_initiator_if bus1();

    cpu_bus_initiator #(.PHI_DIV(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
    cpu_bus_initiator #(.PHI_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

    // Responder: directed value when ovr is set, otherwise a function of the address.
    assign bus0.db_in = ovr ? din : (bus0.ab[7:0] ^ 8'hA5);
    assign bus1.db_in = din1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bnd0();
        logic p;
        logic hit;
        p = bus0.phi2;
        hit = 1'b0;
        for (int n = 0; n < 64 && !hit; n++) begin
            step();
            if (p && !bus0.phi2) hit = 1'b1;
            p = bus0.phi2;
        end
        chk("boundary_reached", {31'd0, hit}, 32'd1);
    endtask

    task automatic wait_high0();
        for (int n = 0; n < 64 && !bus0.phi2; n++) step();
        chk("phi2_high_reached", {31'd0, bus0.phi2}, 32'd1);
    endtask

    task automatic wait_done0();
        for (int n = 0; n < 256 && !bus0.done; n++) step();
        chk("done_reached", {31'd0, bus0.done}, 32'd1);
    endtask

    task automatic issue0(input logic [23:0] a, input logic we, input logic [7:0] wd, input logic vp);
        for (int n = 0; n < 64 && !bus0.req_ready; n++) step();
        bus0.req       = 1'b1;
        bus0.req_addr  = a;
        bus0.req_we    = we;
        bus0.req_wdata = wd;
        bus0.req_vp    = vp;
        step();
        bus0.req = 1'b0;
    endtask

    // Scoreboard monitors: every done pulse pops one expected rdata.
    initial begin : mon0
        logic [7:0] e;
        forever begin
            step();
            if (bus0.done) begin
                if (sb0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done0: done seen with no outstanding request at cycle %0d", cyc);
                end else begin
                    e = sb0.pop_front();
                    chk("rdata0", {24'd0, bus0.rdata}, {24'd0, e});
                end
            end
        end
    end

    initial begin : mon1
        logic [7:0] e;
        forever begin
            step();
            if (bus1.done) begin
                if (sb1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done1: done seen with no outstanding request at cycle %0d", cyc);
                end else begin
                    e = sb1.pop_front();
                    chk("rdata1", {24'd0, bus1.rdata}, {24'd0, e});
                end
            end
        end
    end

    initial begin : stim
        int t0;
        logic p;
        logic [23:0] b2b_addr [4];
        logic [7:0]  b2b_exp  [4];
        b2b_addr = '{24'h000100, 24'h000101, 24'h000102, 24'h000103};
        b2b_exp  = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

        bus0.req = 1'b0; bus0.req_addr = '0; bus0.req_we = 1'b0; bus0.req_wdata = '0; bus0.req_vp = 1'b0;
        bus0.rdy = 1'b1;
        bus1.req = 1'b0; bus1.req_addr = '0; bus1.req_we = 1'b0; bus1.req_wdata = '0; bus1.req_vp = 1'b0;
        bus1.rdy = 1'b1;

        // Reset values
        repeat (3) step();
        chk("rst_phi2",  {31'd0, bus0.phi2},  32'd0);
        chk("rst_ab",    {16'd0, bus0.ab},    32'd0);
        chk("rst_db_oe", {31'd0, bus0.db_oe}, 32'd0);
        chk("rst_rwb",   {31'd0, bus0.rwb},   32'd1);
        chk("rst_vda",   {31'd0, bus0.vda},   32'd0);
        chk("rst_ready", {31'd0, bus0.req_ready}, 32'd1);
        chk("rst_rdata", {24'd0, bus0.rdata}, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_low", {31'd0, bus0.phi2}, 32'd0);

        // Opcode fetch read from ROM
        din = 8'hA9;
        sb0.push_back(8'hA9);
        issue0(24'h00C000, 1'b0, 8'h00, 1'b1);
        chk("rd_ready_low", {31'd0, bus0.req_ready}, 32'd0);
        wait_bnd0();
        t0 = cyc;
        chk("rd_ab",     {16'd0, bus0.ab}, 32'h0000C000);
        chk("rd_vda",    {31'd0, bus0.vda}, 32'd1);
        chk("rd_vpa",    {31'd0, bus0.vpa}, 32'd1);
        chk("rd_rwb",    {31'd0, bus0.rwb}, 32'd1);
        chk("rd_low_oe", {31'd0, bus0.db_oe}, 32'd1);
        chk("rd_bank",   {24'd0, bus0.db_out}, 32'h00);
        wait_high0();
        chk("rd_high_oe", {31'd0, bus0.db_oe}, 32'd0);
        wait_done0();
        chk("rd_latency", cyc - t0, 32'd4);
        step();
        chk("rd_done_pulse", {31'd0, bus0.done}, 32'd0);

        // Write; rdata must keep the previous read value
        sb0.push_back(8'hA9);
        issue0(24'h127FFF, 1'b1, 8'h5A, 1'b0);
        wait_bnd0();
        t0 = cyc;
        chk("wr_ab",      {16'd0, bus0.ab}, 32'h00007FFF);
        chk("wr_bank",    {24'd0, bus0.db_out}, 32'h12);
        chk("wr_low_oe",  {31'd0, bus0.db_oe}, 32'd1);
        wait_high0();
        chk("wr_data",    {24'd0, bus0.db_out}, 32'h5A);
        chk("wr_high_oe", {31'd0, bus0.db_oe}, 32'd1);
        chk("wr_rwb",     {31'd0, bus0.rwb}, 32'd0);
        chk("wr_vda",     {31'd0, bus0.vda}, 32'd1);
        chk("wr_vpa",     {31'd0, bus0.vpa}, 32'd0);
        wait_done0();
        chk("wr_latency", cyc - t0, 32'd4);

        // rdy low at two boundaries stretches the cycle twice
        din = 8'h11;
        sb0.push_back(8'h3C);
        issue0(24'h008001, 1'b0, 8'h00, 1'b0);
        wait_bnd0();
        t0 = cyc;
        bus0.rdy = 1'b0;
        wait_bnd0();
        chk("st1_no_done", {31'd0, bus0.done}, 32'd0);
        chk("st1_ab",      {16'd0, bus0.ab}, 32'h00008001);
        chk("st1_bank",    {24'd0, bus0.db_out}, 32'h00);
        chk("st1_oe",      {31'd0, bus0.db_oe}, 32'd1);
        chk("st1_vda",     {31'd0, bus0.vda}, 32'd1);
        wait_bnd0();
        chk("st2_no_done", {31'd0, bus0.done}, 32'd0);
        chk("st2_ab",      {16'd0, bus0.ab}, 32'h00008001);
        bus0.rdy = 1'b1;
        din = 8'h3C;
        wait_done0();
        chk("st_latency", cyc - t0, 32'd12);

        // Back-to-back reads with the address-derived responder
        ovr = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    sb0.push_back(b2b_exp[i]);
                    issue0(b2b_addr[i], 1'b0, 8'h00, 1'b0);
                    chk("b2b_ready_low", {31'd0, bus0.req_ready}, 32'd0);
                end
            end
            begin
                int nd;
                int last;
                int gaps;
                nd = 0; last = 0; gaps = 0;
                for (int n = 0; n < 64 && !bus0.vda; n++) step();
                for (int k = 0; k < 64 && nd < 4; k++) begin
                    step();
                    if (bus0.done) begin
                        nd++;
                        if (nd > 1) chk("b2b_spacing", cyc - last, 32'd4);
                        last = cyc;
                    end
                    if (nd < 4 && !bus0.vda) gaps++;
                end
                chk("b2b_dones", nd, 32'd4);
                chk("b2b_gaps", gaps, 32'd0);
            end
        join

        // Reset in the middle of a write's HIGH phase
        ovr = 1'b1;
        issue0(24'h001234, 1'b1, 8'h77, 1'b0);
        wait_bnd0();
        wait_high0();
        chk("rw_data", {24'd0, bus0.db_out}, 32'h77);
        #2;
        reset = 1'b1;
        #1;
        chk("rr_phi2",  {31'd0, bus0.phi2},  32'd0);
        chk("rr_ab",    {16'd0, bus0.ab},    32'd0);
        chk("rr_dbout", {24'd0, bus0.db_out}, 32'd0);
        chk("rr_oe",    {31'd0, bus0.db_oe}, 32'd0);
        chk("rr_rwb",   {31'd0, bus0.rwb},   32'd1);
        chk("rr_vda",   {31'd0, bus0.vda},   32'd0);
        chk("rr_rdata", {24'd0, bus0.rdata}, 32'd0);
        chk("rr_ready", {31'd0, bus0.req_ready}, 32'd1);
        repeat (3) step();
        chk("rr_no_done", {31'd0, bus0.done}, 32'd0);
        reset = 1'b0;
        step();
        chk("rel_low",  {31'd0, bus0.phi2},  32'd0);
        chk("rel_vda",  {31'd0, bus0.vda},   32'd0);
        chk("rel_oe",   {31'd0, bus0.db_oe}, 32'd0);
        din = 8'hE1;
        sb0.push_back(8'hE1);
        issue0(24'h00C005, 1'b0, 8'h00, 1'b1);
        wait_bnd0();
        t0 = cyc;
        chk("rel_ab", {16'd0, bus0.ab}, 32'h0000C005);
        wait_done0();
        chk("rel_latency", cyc - t0, 32'd4);

        // PHI_DIV=1 instance: phi2 toggles every clk, read takes 2 clk
        p = bus1.phi2;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("d1_toggle", {31'd0, bus1.phi2}, {31'd0, ~p});
            p = bus1.phi2;
        end
        sb1.push_back(8'h42);
        bus1.req = 1'b1; bus1.req_addr = 24'h00C010; bus1.req_we = 1'b0; bus1.req_vp = 1'b1;
        step();
        bus1.req = 1'b0;
        begin
            logic hit;
            hit = 1'b0;
            p = bus1.phi2;
            for (int n = 0; n < 16 && !hit; n++) begin
                step();
                if (p && !bus1.phi2 && bus1.vda) hit = 1'b1;
                p = bus1.phi2;
            end
            chk("d1_start", {31'd0, hit}, 32'd1);
        end
        t0 = cyc;
        chk("d1_ab", {16'd0, bus1.ab}, 32'h0000C010);
        for (int n = 0; n < 16 && !bus1.done; n++) step();
        chk("d1_done", {31'd0, bus1.done}, 32'd1);
        chk("d1_latency", cyc - t0, 32'd2);

        repeat (4) step();
        chk("sb0_drained", sb0.size(), 32'd0);
        chk("sb1_drained", sb1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
